// File: rtl/multi_alarm_bell_pkg.sv
// Purpose: shared types for the multi-channel alarm engine (BCD time, day encoding, FSM states).
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package multi_alarm_bell_pkg;

  typedef logic [7:0] bcd_hour_t;
  typedef logic [7:0] bcd_min_t;

  localparam int N_DAYS = 7;
  typedef logic [2:0]        day_t;
  typedef logic [N_DAYS-1:0] day_mask_t;

  // Day code 7 is the "no valid day" value from the timekeeper; it never matches.
  localparam day_t DAY_NONE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_t;

  typedef struct packed {
    logic      en;
    day_mask_t days;
    bcd_hour_t hour;
    bcd_min_t  minute;
  } alarm_cfg_t;

  function automatic logic day_hit(input day_mask_t days, input day_t wd);
    logic [7:0] ext;
    ext = {1'b0, days};
    return (wd != DAY_NONE) && ext[wd];
  endfunction

endpackage

// File: rtl/multi_alarm_bell_alarm_match.sv
// Purpose: one alarm channel -- stored config plus combinational match against running time.
// Latency: config registered on the edge after cfg_we; match is combinational (same cycle as tick).
// Backpressure: none; writes and ticks are always accepted.
// Ports: clk_50M/rst_n, cfg_we + cfg_dat (this channel's write), tick/time/day inputs, match out.
module multi_alarm_bell_alarm_match
  import multi_alarm_bell_pkg::*;
(
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  alarm_cfg_t cfg_dat,
  input  logic       tick_1Hz,
  input  bcd_hour_t  hour_time,
  input  bcd_min_t   minute_time,
  input  logic [7:0] second_time,
  input  day_t       week_day,
  output logic       match
);

  alarm_cfg_t cfg_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else if (cfg_we) begin
      cfg_q <= cfg_dat;
    end
  end

  // Only the tick at second 00 can fire, so each minute produces at most one match.
  assign match = tick_1Hz && (second_time == 8'h00) && cfg_q.en &&
                 (hour_time == cfg_q.hour) && (minute_time == cfg_q.minute) &&
                 day_hit(cfg_q.days, week_day);

endmodule

// File: rtl/multi_alarm_bell.sv
// Purpose: N-channel alarm engine -- priority select of matching channel, ring/snooze FSM, buzzer tone.
// Latency: ringing/ring_ch assert one cycle after the matching tick; keys act on the next edge.
// Backpressure: none; ticks and key pulses are consumed the cycle they arrive.
// Ports: clk_50M, rst_n, tick_1Hz, hour/minute/second_time, week_day, cfg_* write port,
//        snooze_key, stop_key in; bell_out, ringing, snoozing, ring_ch out.
module multi_alarm_bell
  import multi_alarm_bell_pkg::*;
#(
  parameter int N_ALARM    = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int TONE_DIV   = 25000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       tick_1Hz,
  input  logic [7:0] hour_time,
  input  logic [7:0] minute_time,
  input  logic [7:0] second_time,
  input  logic [2:0] week_day,
  input  logic       cfg_we,
  input  logic [2:0] cfg_idx,
  input  logic [7:0] cfg_hour,
  input  logic [7:0] cfg_minute,
  input  logic       cfg_en,
  input  logic [6:0] cfg_days,
  input  logic       snooze_key,
  input  logic       stop_key,
  output logic       bell_out,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] ring_ch
);

  localparam int RW = $clog2(RING_SEC + 1);
  localparam int WW = $clog2(SNOOZE_SEC + 1);
  localparam int SW = $clog2(MAX_SNOOZE + 1);
  localparam int TW = $clog2(TONE_DIV + 1);

  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SEC - 1);
  localparam logic [WW-1:0] SNOOZE_LAST = WW'(SNOOZE_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_MAX  = SW'(MAX_SNOOZE);
  localparam logic [TW-1:0] TONE_LAST   = TW'(TONE_DIV - 1);

  // ---- per-channel config and match ----
  alarm_cfg_t         cfg_dat;
  logic [N_ALARM-1:0] match_vec;

  assign cfg_dat = '{en: cfg_en, days: cfg_days, hour: cfg_hour, minute: cfg_minute};

  for (genvar i = 0; i < N_ALARM; i++) begin : g_ch
    multi_alarm_bell_alarm_match u_alarm_match (
      .clk_50M     (clk_50M),
      .rst_n       (rst_n),
      .cfg_we      (cfg_we && (cfg_idx == 3'(i))),
      .cfg_dat     (cfg_dat),
      .tick_1Hz    (tick_1Hz),
      .hour_time   (hour_time),
      .minute_time (minute_time),
      .second_time (second_time),
      .week_day    (week_day),
      .match       (match_vec[i])
    );
  end

  // Lowest index wins; the losing channels' matches for this minute are simply dropped.
  logic       match_any;
  logic [2:0] match_ch;

  always_comb begin
    match_any = 1'b0;
    match_ch  = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        match_any = 1'b1;
        match_ch  = 3'(i);
      end
    end
  end

  // ---- ring / snooze FSM ----
  alarm_state_t  state_q, state_d;
  logic [2:0]    ch_q, ch_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [SW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic          beat_q, beat_d;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      ring_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      beat_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      ring_cnt_q   <= ring_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      beat_q       <= beat_d;
    end
  end

  // Within each state, keys are tested before the tick so a key always beats a terminal tick.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    ring_cnt_d   = ring_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    beat_d       = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (match_any) begin
          state_d      = ST_RING;
          ch_d         = match_ch;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
          beat_d       = 1'b0;
        end
      end
      ST_RING: begin
        if (stop_key) begin
          state_d = ST_IDLE;
        end else if (snooze_key) begin
          if (snooze_cnt_q < SNOOZE_MAX) begin
            state_d      = ST_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 1'b1;
            wait_cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;   // snooze budget spent: the key dismisses
          end
        end else if (tick_1Hz) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d = ST_IDLE;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
            beat_d     = ~beat_q;
          end
        end
      end
      ST_SNOOZE: begin
        if (stop_key) begin
          state_d = ST_IDLE;
        end else if (match_any) begin
          // A fresh alarm pre-empts the snoozed one and gets its own snooze budget.
          state_d      = ST_RING;
          ch_d         = match_ch;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
          beat_d       = 1'b0;
        end else if (tick_1Hz) begin
          if (wait_cnt_q == SNOOZE_LAST) begin
            state_d    = ST_RING;
            ring_cnt_d = '0;
            beat_d     = 1'b0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      ch_d         = '0;
      ring_cnt_d   = '0;
      wait_cnt_d   = '0;
      snooze_cnt_d = '0;
      beat_d       = 1'b0;
    end
  end

  // ---- tone divider (free running, independent of FSM) ----
  logic [TW-1:0] tone_cnt_q;
  logic          tone_sq;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      tone_sq    <= 1'b0;
    end else if (tone_cnt_q == TONE_LAST) begin
      tone_cnt_q <= '0;
      tone_sq    <= ~tone_sq;
    end else begin
      tone_cnt_q <= tone_cnt_q + 1'b1;
    end
  end

  // All terms come from async-reset flops, so bell_out falls as soon as rst_n drops.
  assign ringing  = (state_q == ST_RING);
  assign snoozing = (state_q == ST_SNOOZE);
  assign ring_ch  = ch_q;
  assign bell_out = ringing && !beat_q && tone_sq;

endmodule

// File: tb/tb_multi_alarm_bell.sv
module tb_multi_alarm_bell;

  localparam int N_ALARM    = 4;
  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;
  localparam int MAX_SNOOZE = 3;
  localparam int TONE_DIV   = 4;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1Hz = 1'b0;
  logic [7:0] hour_time = '0, minute_time = '0, second_time = '0;
  logic [2:0] week_day = '0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [7:0] cfg_hour = '0, cfg_minute = '0;
  logic       cfg_en = 1'b0;
  logic [6:0] cfg_days = '0;
  logic       snooze_key = 1'b0, stop_key = 1'b0;
  logic       bell_out, ringing, snoozing;
  logic [2:0] ring_ch;

  always #5 clk_50M = ~clk_50M;

  multi_alarm_bell #(
    .N_ALARM(N_ALARM), .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC),
    .MAX_SNOOZE(MAX_SNOOZE), .TONE_DIV(TONE_DIV)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .tick_1Hz(tick_1Hz),
    .hour_time(hour_time), .minute_time(minute_time), .second_time(second_time),
    .week_day(week_day), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_hour(cfg_hour),
    .cfg_minute(cfg_minute), .cfg_en(cfg_en), .cfg_days(cfg_days),
    .snooze_key(snooze_key), .stop_key(stop_key), .bell_out(bell_out),
    .ringing(ringing), .snoozing(snoozing), .ring_ch(ring_ch)
  );

  int n_asserts = 0;
  int n_fails   = 0;

  // ---- reference model: "what the user hears", in seconds remaining ----
  logic       m_en   [N_ALARM];
  logic [7:0] m_hour [N_ALARM];
  logic [7:0] m_min  [N_ALARM];
  logic [6:0] m_days [N_ALARM];
  int m_mode;          // 0 quiet, 1 ringing, 2 snoozing
  int m_ch;
  int m_ring_left;     // seconds of ringing left
  int m_snooze_left;   // seconds of snooze left
  int m_snoozes;       // snoozes used for this alarm event
  int m_edges;         // clock edges since reset release (tone phase)

  task automatic model_reset();
    for (int c = 0; c < N_ALARM; c++) begin
      m_en[c] = 1'b0; m_hour[c] = '0; m_min[c] = '0; m_days[c] = '0;
    end
    m_mode = 0; m_ch = 0; m_ring_left = 0; m_snooze_left = 0; m_snoozes = 0; m_edges = 0;
  endtask

  function automatic logic m_bell();
    return (m_mode == 1) && (((RING_SEC - m_ring_left) % 2) == 0) &&
           (((m_edges / TONE_DIV) % 2) == 1);
  endfunction

  task automatic model_edge();
    int hit;
    hit = -1;
    if (tick_1Hz && second_time == 8'h00 && week_day != 3'd7)
      for (int c = 0; c < N_ALARM; c++)
        if (hit < 0 && m_en[c] && m_hour[c] == hour_time && m_min[c] == minute_time &&
            m_days[c][week_day])
          hit = c;
    case (m_mode)
      0: if (hit >= 0) begin
           m_mode = 1; m_ch = hit; m_ring_left = RING_SEC; m_snoozes = 0;
         end
      1: if (stop_key) m_mode = 0;
         else if (snooze_key) begin
           if (m_snoozes < MAX_SNOOZE) begin
             m_mode = 2; m_snoozes++; m_snooze_left = SNOOZE_SEC;
           end else m_mode = 0;
         end else if (tick_1Hz) begin
           m_ring_left--;
           if (m_ring_left == 0) m_mode = 0;
         end
      default: if (stop_key) m_mode = 0;
         else if (hit >= 0) begin
           m_mode = 1; m_ch = hit; m_snoozes = 0; m_ring_left = RING_SEC;
         end else if (tick_1Hz) begin
           m_snooze_left--;
           if (m_snooze_left == 0) begin m_mode = 1; m_ring_left = RING_SEC; end
         end
    endcase
    if (cfg_we && cfg_idx < N_ALARM) begin
      m_en[cfg_idx] = cfg_en; m_hour[cfg_idx] = cfg_hour;
      m_min[cfg_idx] = cfg_minute; m_days[cfg_idx] = cfg_days;
    end
    m_edges++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("ringing",  {31'd0, ringing},  {31'd0, m_mode == 1});
    chk("snoozing", {31'd0, snoozing}, {31'd0, m_mode == 2});
    chk("ring_ch",  {29'd0, ring_ch},  (m_mode == 0) ? 32'd0 : 32'(m_ch));
    chk("bell_out", {31'd0, bell_out}, {31'd0, m_bell()});
  endtask

  // One clock: inputs already driven; model steps on the edge, outputs sampled on negedge.
  task automatic cyc();
    @(posedge clk_50M);
    model_edge();
    @(negedge clk_50M);
    check_all();
    tick_1Hz = 1'b0; cfg_we = 1'b0; snooze_key = 1'b0; stop_key = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [7:0] h, input logic [7:0] m,
                           input logic en, input logic [6:0] days);
    cfg_idx = idx; cfg_hour = h; cfg_minute = m; cfg_en = en; cfg_days = days; cfg_we = 1'b1;
    cyc();
  endtask

  task automatic tick_at(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic [2:0] wd);
    hour_time = h; minute_time = m; second_time = s; week_day = wd; tick_1Hz = 1'b1;
    cyc();
  endtask

  task automatic ticks(input int n);
    second_time = 8'h01;
    repeat (n) begin
      tick_1Hz = 1'b1; cyc(); cyc();
    end
  endtask

  logic [7:0] tbl_h [3];
  logic [7:0] tbl_m [3];

  initial begin
    tbl_h[0] = 8'h06; tbl_h[1] = 8'h07; tbl_h[2] = 8'h12;
    tbl_m[0] = 8'h00; tbl_m[1] = 8'h30; tbl_m[2] = 8'h45;
    model_reset();

    // Reset state
    @(negedge clk_50M); @(negedge clk_50M);
    chk("rst_ringing", {31'd0, ringing}, 32'd0);
    chk("rst_snoozing", {31'd0, snoozing}, 32'd0);
    chk("rst_bell", {31'd0, bell_out}, 32'd0);
    chk("rst_ring_ch", {29'd0, ring_ch}, 32'd0);
    rst_n = 1'b1;

    // Basic ring on ch1 and auto-dismiss after RING_SEC ticks
    cfg_write(3'd1, 8'h07, 8'h30, 1'b1, 7'h1F);
    tick_at(8'h07, 8'h30, 8'h00, 3'd0);
    chk("s1_ringing", {31'd0, ringing}, 32'd1);
    chk("s1_ring_ch", {29'd0, ring_ch}, 32'd1);
    ticks(RING_SEC - 1);
    chk("s1_still_ringing", {31'd0, ringing}, 32'd1);
    ticks(1);
    chk("s1_timeout", {31'd0, ringing}, 32'd0);
    chk("s1_ch_cleared", {29'd0, ring_ch}, 32'd0);

    // Simultaneous match: lowest index wins, loser dropped for that minute
    cfg_write(3'd0, 8'h06, 8'h00, 1'b1, 7'h7F);
    cfg_write(3'd2, 8'h06, 8'h00, 1'b1, 7'h7F);
    tick_at(8'h06, 8'h00, 8'h00, 3'd0);
    chk("s2_ring_ch", {29'd0, ring_ch}, 32'd0);
    stop_key = 1'b1; cyc();
    chk("s2_stopped", {31'd0, ringing}, 32'd0);
    for (int s = 1; s < 6; s++) begin
      tick_at(8'h06, 8'h00, 8'(s), 3'd0);
      chk("s2_no_ch2", {31'd0, ringing}, 32'd0);
    end

    // Snooze three times, fourth snooze dismisses
    tick_at(8'h07, 8'h30, 8'h00, 3'd0);
    for (int k = 0; k < MAX_SNOOZE; k++) begin
      snooze_key = 1'b1; cyc();
      chk("s3_snoozing", {31'd0, snoozing}, 32'd1);
      chk("s3_bell_quiet", {31'd0, bell_out}, 32'd0);
      ticks(SNOOZE_SEC - 1);
      chk("s3_still_snoozing", {31'd0, snoozing}, 32'd1);
      ticks(1);
      chk("s3_rering", {31'd0, ringing}, 32'd1);
      chk("s3_rering_ch", {29'd0, ring_ch}, 32'd1);
    end
    snooze_key = 1'b1; cyc();
    chk("s3_fourth_idle", {31'd0, ringing | snoozing}, 32'd0);

    // Weekday mask
    tick_at(8'h07, 8'h30, 8'h00, 3'd5);
    chk("s4_sat", {31'd0, ringing}, 32'd0);
    tick_at(8'h07, 8'h30, 8'h00, 3'd6);
    chk("s4_sun", {31'd0, ringing}, 32'd0);
    tick_at(8'h07, 8'h30, 8'h00, 3'd7);
    chk("s4_day7", {31'd0, ringing}, 32'd0);
    tick_at(8'h07, 8'h30, 8'h00, 3'd4);
    chk("s4_fri", {31'd0, ringing}, 32'd1);

    // stop + snooze together: stop wins
    stop_key = 1'b1; snooze_key = 1'b1; cyc();
    chk("s5_both_keys", {31'd0, ringing | snoozing}, 32'd0);

    // Key beats terminal tick (RING and SNOOZE)
    tick_at(8'h07, 8'h30, 8'h00, 3'd0);
    ticks(RING_SEC - 1);
    second_time = 8'h01; tick_1Hz = 1'b1; snooze_key = 1'b1; cyc();
    chk("s6_snooze_beats_tick", {31'd0, snoozing}, 32'd1);
    ticks(SNOOZE_SEC - 1);
    tick_1Hz = 1'b1; stop_key = 1'b1; cyc();
    chk("s6_stop_beats_tick", {31'd0, ringing | snoozing}, 32'd0);

    // New match pre-empts a snooze
    tick_at(8'h07, 8'h30, 8'h00, 3'd0);
    snooze_key = 1'b1; cyc();
    ticks(5);
    tick_at(8'h06, 8'h00, 8'h00, 3'd1);
    chk("s7_preempt", {31'd0, ringing}, 32'd1);
    chk("s7_preempt_ch", {29'd0, ring_ch}, 32'd0);
    stop_key = 1'b1; cyc();

    // Out-of-range channel writes are ignored
    cfg_write(3'd4, 8'h09, 8'h00, 1'b1, 7'h7F);
    cfg_write(3'd7, 8'h09, 8'h00, 1'b1, 7'h7F);
    tick_at(8'h09, 8'h00, 8'h00, 3'd0);
    chk("s8_idx_oob", {31'd0, ringing}, 32'd0);

    // Randomized traffic checked cycle by cycle against the model
    for (int c = 0; c < N_ALARM; c++) begin
      int t;
      t = $urandom_range(0, 2);
      cfg_write(3'(c), tbl_h[t], tbl_m[t], 1'($urandom_range(0, 3) != 0), 7'($urandom));
    end
    for (int i = 0; i < 4000; i++) begin
      int t;
      t = $urandom_range(0, 2);
      hour_time   = tbl_h[t];
      minute_time = tbl_m[t];
      second_time = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h17;
      week_day    = 3'($urandom_range(0, 7));
      tick_1Hz    = ($urandom_range(0, 2) == 0);
      snooze_key  = ($urandom_range(0, 39) == 0);
      stop_key    = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 199) == 0) begin
        cfg_we = 1'b1; cfg_idx = 3'($urandom_range(0, 7));
        cfg_hour = tbl_h[t]; cfg_minute = tbl_m[t];
        cfg_en = 1'($urandom); cfg_days = 7'($urandom);
      end
      cyc();
    end
    stop_key = 1'b1; cyc();

    // Asynchronous reset while the bell is sounding
    cfg_write(3'd1, 8'h07, 8'h30, 1'b1, 7'h1F);
    tick_at(8'h07, 8'h30, 8'h00, 3'd0);
    for (int i = 0; i < 40 && !m_bell(); i++) cyc();
    chk("s9_bell_on", {31'd0, bell_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s9_bell_async", {31'd0, bell_out}, 32'd0);
    chk("s9_ringing_async", {31'd0, ringing}, 32'd0);
    chk("s9_ch_async", {29'd0, ring_ch}, 32'd0);
    model_reset();
    @(negedge clk_50M);
    rst_n = 1'b1;
    tick_at(8'h07, 8'h30, 8'h00, 3'd0);
    chk("s9_cfg_cleared", {31'd0, ringing}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
